// File: rtl/mel_pkg.sv
// Shared defaults and read-side state type for the mel output scheduler.
package mel_pkg;

  localparam int MEL_BINS_DEF = 40;
  localparam int DATA_W_DEF   = 16;
  localparam int DROP_CNT_W   = 16;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/mel_out_sched_if.sv
// Valid/ready stream from the scheduler towards the CNN, with a last-beat marker.
interface mel_out_sched_if
  import mel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/mel_bank_rf.sv
// Two-bank mel register file: one synchronous write port, one combinational read port.
module mel_bank_rf
  import mel_pkg::*;
#(
  parameter int  MEL_BINS = MEL_BINS_DEF,
  parameter int  DATA_W   = DATA_W_DEF,
  localparam int IDX_W    = $clog2(MEL_BINS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rbank_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents are deliberately not reset; unwritten entries keep stale data.
  logic [DATA_W-1:0] mem_q [2][MEL_BINS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wbank_i][widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rbank_i][ridx_i];

endmodule

// File: rtl/mel_out_sched.sv
// Ping-pong frame scheduler between the log-mel writer and the CNN stream.
// Optional feature: define MEL_OUT_DROP_CNT_EN to add the dropped-frame counter drop_cnt_o.
module mel_out_sched
  import mel_pkg::*;
#(
  parameter int  MEL_BINS = MEL_BINS_DEF,
  parameter int  DATA_W   = DATA_W_DEF,
  localparam int IDX_W    = $clog2(MEL_BINS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_last_i,
  output logic              wr_ready_o,
  mel_out_sched_if.master   m_if,
  output logic              frame_sent_o,
  output logic [1:0]        frames_pending_o
`ifdef MEL_OUT_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

  rd_state_e         state_q, state_d;
  logic              wBank_q, wBank_d;
  logic              rBank_q, rBank_d;
  logic [1:0]        full_q, full_d;
  logic [IDX_W-1:0]  rdIdx_q, rdIdx_d;
  logic              frameSent_q, frameSent_d;

  logic              wrAccept, wrInRange, wrClose;
  logic              mValid, rdFire, rdAtLast;
  logic [DATA_W-1:0] rfRdata;

  assign wr_ready_o = !full_q[wBank_q];
  assign wrAccept   = wr_en_i & wr_ready_o;
  assign wrInRange  = 32'(wr_idx_i) < 32'(MEL_BINS);
  assign wrClose    = wrAccept & wr_last_i;

  assign rdAtLast   = (rdIdx_q == IDX_W'(MEL_BINS - 1));
  assign rdFire     = mValid & m_if.m_ready;

  mel_bank_rf #(
    .MEL_BINS (MEL_BINS),
    .DATA_W   (DATA_W)
  ) u_bank_rf (
    .clk     (clk),
    .we_i    (wrAccept & wrInRange),
    .wbank_i (wBank_q),
    .widx_i  (wr_idx_i),
    .wdata_i (wr_data_i),
    .rbank_i (rBank_q),
    .ridx_i  (rdIdx_q),
    .rdata_o (rfRdata)
  );

  always_comb begin
    state_d = state_q;
    mValid  = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rBank_q]) begin
          state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        mValid = 1'b1;
        if (m_if.m_ready && rdAtLast) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Closing and draining always hit different banks, so both updates can apply together.
  always_comb begin
    full_d      = full_q;
    wBank_d     = wBank_q;
    rBank_d     = rBank_q;
    rdIdx_d     = rdIdx_q;
    frameSent_d = 1'b0;
    if (wrClose) begin
      full_d[wBank_q] = 1'b1;
      wBank_d         = !wBank_q;
    end
    if (rdFire) begin
      if (rdAtLast) begin
        rdIdx_d         = '0;
        full_d[rBank_q] = 1'b0;
        rBank_d         = !rBank_q;
        frameSent_d     = 1'b1;
      end else begin
        rdIdx_d = rdIdx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RD_IDLE;
      wBank_q     <= 1'b0;
      rBank_q     <= 1'b0;
      full_q      <= '0;
      rdIdx_q     <= '0;
      frameSent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wBank_q     <= wBank_d;
      rBank_q     <= rBank_d;
      full_q      <= full_d;
      rdIdx_q     <= rdIdx_d;
      frameSent_q <= frameSent_d;
    end
  end

  assign m_if.m_valid     = mValid;
  assign m_if.m_data      = rfRdata;
  assign m_if.m_last      = mValid & rdAtLast;
  assign frame_sent_o     = frameSent_q;
  assign frames_pending_o = 2'(full_q[0]) + 2'(full_q[1]);

`ifdef MEL_OUT_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] dropCnt_q;

  // Only a dropped frame-closing write counts; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropCnt_q <= '0;
    end else if (wr_en_i && !wr_ready_o && wr_last_i && (dropCnt_q != '1)) begin
      dropCnt_q <= dropCnt_q + 1'b1;
    end
  end

  assign drop_cnt_o = dropCnt_q;
`endif

endmodule

// File: tb/tb_mel_out_sched.sv
// Scoreboard bench for mel_out_sched: randomized frames against a frame-level buffer model.
// Define MEL_OUT_DROP_CNT_EN to also check drop_cnt_o.
`timescale 1ns/1ps
module tb_mel_out_sched;
  import mel_pkg::*;

  localparam int MEL_BINS = MEL_BINS_DEF;
  localparam int DATA_W   = DATA_W_DEF;
  localparam int IDX_W    = $clog2(MEL_BINS);

  typedef struct {
    int data;
    bit last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wrEn;
  logic [IDX_W-1:0]  wrIdx;
  logic [DATA_W-1:0] wrData;
  logic              wrLast;
  logic              wrReady;
  logic              frameSent;
  logic [1:0]        framesPending;
`ifdef MEL_OUT_DROP_CNT_EN
  logic [15:0]       dropCnt;
`endif

  mel_out_sched_if #(.DATA_W(DATA_W)) mIf ();

  int    nCompared   = 0;
  int    nMismatched = 0;
  beat_t expQ[$];
  int    modelMem[2][MEL_BINS];
  int    modelWbank  = 0;
  int    dropExp     = 0;
  int    beatTotal   = 0;
  int    sentCount   = 0;
  int    readyMode   = 0;

  mel_out_sched #(
    .MEL_BINS (MEL_BINS),
    .DATA_W   (DATA_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_en_i          (wrEn),
    .wr_idx_i         (wrIdx),
    .wr_data_i        (wrData),
    .wr_last_i        (wrLast),
    .wr_ready_o       (wrReady),
    .m_if             (mIf),
    .frame_sent_o     (frameSent),
    .frames_pending_o (framesPending)
`ifdef MEL_OUT_DROP_CNT_EN
    ,
    .drop_cnt_o       (dropCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Writes one frame; the model keeps the last value written to each slot of each buffer.
  task automatic applyStimulus(input int pattern, input bit oor, input bit gaps, input bit accept);
    int idxVal;
    int dataVal;
    for (int i = 0; i < MEL_BINS; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          wrEn = 1'b0;
          @(posedge clk); #1;
        end
      end
      idxVal  = (oor && i == MEL_BINS - 1) ? 45 : i;
      dataVal = (pattern == 0) ? i * 3 : int'($urandom_range(0, 65535));
      wrEn    = 1'b1;
      wrIdx   = IDX_W'(idxVal);
      wrData  = DATA_W'(dataVal);
      wrLast  = (i == MEL_BINS - 1);
      @(posedge clk); #1;
      if (accept && idxVal < MEL_BINS) modelMem[modelWbank][idxVal] = dataVal;
    end
    wrEn   = 1'b0;
    wrLast = 1'b0;
    if (accept) begin
      for (int i = 0; i < MEL_BINS; i++)
        expQ.push_back('{data: modelMem[modelWbank][i], last: (i == MEL_BINS - 1)});
      modelWbank ^= 1;
    end else begin
      dropExp++;
    end
  endtask

  task automatic waitReady();
    int n = 0;
    while (!wrReady && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("wait_wr_ready", int'(wrReady), 1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || mIf.m_valid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_beats_left", expQ.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    mIf.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0:       mIf.m_ready = 1'b1;
        1:       mIf.m_ready = ~mIf.m_ready;
        2:       mIf.m_ready = 1'($urandom_range(0, 1));
        default: mIf.m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability and pulses.
  initial begin
    bit    sentExp   = 1'b0;
    bit    prevStall = 1'b0;
    int    prevData  = 0;
    beat_t b;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sentExp   = 1'b0;
        prevStall = 1'b0;
      end else begin
        checkOutput("frame_sent", int'(frameSent), int'(sentExp));
        if (frameSent) sentCount++;
        sentExp = 1'b0;
        if (prevStall) begin
          checkOutput("stall_valid", int'(mIf.m_valid), 1);
          checkOutput("stall_data", int'(mIf.m_data), prevData);
        end
        if (mIf.m_valid) begin
          nCompared++;
          if (expQ.size() == 0) begin
            nMismatched++;
            $display("[TB] FAIL beat_expected: got beat data %0d, expected no beat (t=%0t)",
                     mIf.m_data, $time);
          end else begin
            checkOutput("m_last", int'(mIf.m_last), int'(expQ[0].last));
            if (mIf.m_ready) begin
              b = expQ.pop_front();
              checkOutput("m_data", int'(mIf.m_data), b.data);
              sentExp = b.last;
              beatTotal++;
            end
          end
        end else begin
          checkOutput("m_last_idle", int'(mIf.m_last), 0);
        end
        prevStall = mIf.m_valid && !mIf.m_ready;
        prevData  = int'(mIf.m_data);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sentBefore;
    int beatStart;
    int n;
    reset_n = 1'b0;
    wrEn    = 1'b0;
    wrIdx   = '0;
    wrData  = '0;
    wrLast  = 1'b0;
    #3;
    checkOutput("rst_wr_ready", int'(wrReady), 1);
    checkOutput("rst_m_valid", int'(mIf.m_valid), 0);
    checkOutput("rst_m_last", int'(mIf.m_last), 0);
    checkOutput("rst_frame_sent", int'(frameSent), 0);
    checkOutput("rst_pending", int'(framesPending), 0);
`ifdef MEL_OUT_DROP_CNT_EN
    checkOutput("rst_drop_cnt", int'(dropCnt), 0);
`endif
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single frame, idx*3 pattern");
    readyMode  = 0;
    sentBefore = sentCount;
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("single_pending_after_close", int'(framesPending), 1);
    waitDrain();
    checkOutput("single_pending_end", int'(framesPending), 0);
    checkOutput("single_sent_pulses", sentCount - sentBefore, 1);

    $display("[TB] backpressure, ready toggling");
    readyMode = 1;
    beatStart = beatTotal;
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    waitDrain();
    checkOutput("bp_beats", beatTotal - beatStart, MEL_BINS);
    checkOutput("bp_pending_end", int'(framesPending), 0);

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      readyMode = $urandom_range(0, 2);
      waitReady();
      applyStimulus(1, 1'b0, 1'b1, 1'b1);
    end
    readyMode = 0;
    waitDrain();
    checkOutput("rand_pending_end", int'(framesPending), 0);

    $display("[TB] overflow with reader stalled");
    readyMode = 3;
    waitReady();
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_ready_after_f1", int'(wrReady), 1);
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_ready_after_f2", int'(wrReady), 0);
    checkOutput("ovf_pending_after_f2", int'(framesPending), 2);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_pending_after_f3", int'(framesPending), 2);
    checkOutput("ovf_ready_after_f3", int'(wrReady), 0);
`ifdef MEL_OUT_DROP_CNT_EN
    checkOutput("ovf_drop_cnt", int'(dropCnt), dropExp);
`endif
    readyMode = 0;
    waitDrain();
    checkOutput("ovf_pending_end", int'(framesPending), 0);

    $display("[TB] close frame B on frame A's last handshake");
    readyMode  = 0;
    sentBefore = sentCount;
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("simul_pending", int'(framesPending), 1);
    checkOutput("simul_wr_ready", int'(wrReady), 1);
    checkOutput("simul_sent_pulses", sentCount - sentBefore, 1);
    @(posedge clk); #1;
    waitDrain();
    checkOutput("simul_pending_end", int'(framesPending), 0);

    $display("[TB] reset in the middle of a stream");
    readyMode = 0;
    beatStart = beatTotal;
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (beatTotal < beatStart + 20 && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput("rst_mid_beats_seen", beatTotal - beatStart, 20);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_m_valid", int'(mIf.m_valid), 0);
    checkOutput("rst_mid_pending", int'(framesPending), 0);
    checkOutput("rst_mid_wr_ready", int'(wrReady), 1);
    checkOutput("rst_mid_frame_sent", int'(frameSent), 0);
    expQ.delete();
    modelWbank = 0;
    dropExp    = 0;
    sentBefore = sentCount;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_mid_no_sent", sentCount - sentBefore, 0);
    checkOutput("rst_mid_valid_after", int'(mIf.m_valid), 0);
    checkOutput("rst_mid_pending_after", int'(framesPending), 0);
`ifdef MEL_OUT_DROP_CNT_EN
    checkOutput("rst_mid_drop_cnt", int'(dropCnt), dropExp);
`endif

    $display("[TB] out-of-range index closes the frame");
    readyMode = 0;
    beatStart = beatTotal;
    applyStimulus(1, 1'b1, 1'b0, 1'b1);
    checkOutput("oor_pending_after_close", int'(framesPending), 1);
    waitDrain();
    checkOutput("oor_beats", beatTotal - beatStart, MEL_BINS);
    checkOutput("oor_pending_end", int'(framesPending), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
